// File: rtl/bin_bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Converts one value per start request. Results that exceed the BCD range saturate to all nines and raise ovf.
module bin_bcd #(
  parameter int unsigned SIZE_bin = 24,
  parameter int unsigned SIZE_bcd = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZE_bin-1:0] data_bin,
  output logic                busy,
  output logic [SIZE_bcd-1:0] data_bcd,
  output logic                valid,
  output logic                ovf
);

  localparam int unsigned D     = SIZE_bcd / 4;
  localparam int unsigned W     = SIZE_bcd + SIZE_bin;
  localparam int unsigned CNT_W = $clog2(SIZE_bin + 1);
  localparam logic [CNT_W-1:0]    LAST = CNT_W'(SIZE_bin - 1);
  localparam logic [SIZE_bcd-1:0] ALL9 = {D{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e              state_q;
  logic [W-1:0]        work_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                sticky_q;
  logic                busy_q;
  logic                valid_q;
  logic                ovf_q;
  logic [SIZE_bcd-1:0] data_bcd_q;

  logic [SIZE_bcd-1:0] bcd_adj;
  logic [3:0]          dig;
  logic [W-1:0]        work_d;
  logic                carry_out;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift the whole register left.
  always_comb begin
    bcd_adj = '0;
    dig     = '0;
    for (int i = 0; i < int'(D); i++) begin
      dig = work_q[SIZE_bin + 4*i +: 4];
      bcd_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    carry_out = bcd_adj[SIZE_bcd-1];
    work_d    = {bcd_adj[SIZE_bcd-2:0], work_q[SIZE_bin-1:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      data_bcd_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q   <= {{SIZE_bcd{1'b0}}, data_bin};
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          // A one leaving the top digit means the value needs more than D digits.
          if (carry_out) sticky_q <= 1'b1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          data_bcd_q <= sticky_q ? ALL9 : work_q[W-1 -: SIZE_bcd];
          ovf_q      <= sticky_q;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;
  assign data_bcd = data_bcd_q;

endmodule

// File: tb/tb_bin_bcd.sv
// Directed scoreboard bench for bin_bcd: expected results are queued at start and checked on each valid pulse.
module tb_bin_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] data_bin;
  logic        busy;
  logic [27:0] data_bcd;
  logic        valid;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt  = 0;
  logic [28:0] sb_q[$];

  bin_bcd #(.SIZE_bin(24), .SIZE_bcd(28)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_bin (data_bin),
    .busy     (busy),
    .data_bcd (data_bcd),
    .valid    (valid),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (valid === 1'b1) vcnt <= vcnt + 1;

  // Reference: {ovf, bcd} by decimal division.
  function automatic logic [28:0] model(input logic [23:0] v);
    int unsigned x = 32'(v);
    logic [27:0] r = '0;
    if (x > 32'd9999999) return {1'b1, 28'h9999999};
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_conv(input logic [23:0] v, input bit push);
    if (push) sb_q.push_back(model(v));
    data_bin = v;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Waits (bounded) for valid, checks latency/busy, then pops and compares the result.
  task automatic expect_result(input string tag, input int exp_lat);
    int lat = 0;
    int bcnt = 0;
    logic [28:0] e;
    while (valid !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    check({tag, " busy_in_valid"}, 64'(busy), 64'(0));
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 64'(0), 64'(1));
    end else begin
      e = sb_q.pop_front();
      check({tag, " data_bcd"}, 64'(data_bcd), 64'(e[27:0]));
      check({tag, " ovf"}, 64'(ovf), 64'(e[28]));
    end
    tick();
    check({tag, " valid_one_cycle"}, 64'(valid), 64'(0));
  endtask

  initial begin
    int v0;
    rst      = 1'b1;
    start    = 1'b0;
    data_bin = '0;
    tick();
    check("reset busy", 64'(busy), 64'(0));
    check("reset valid", 64'(valid), 64'(0));
    check("reset data_bcd", 64'(data_bcd), 64'(0));
    check("reset ovf", 64'(ovf), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    start_conv(24'd0, 1'b1);
    check("zero busy_rise", 64'(busy), 64'(1));
    expect_result("zero", 25);
    check("zero busy_fall", 64'(busy), 64'(0));

    start_conv(24'h7704C0, 1'b1);
    expect_result("7800000", 25);
    start_conv(24'h98967F, 1'b1);
    expect_result("9999999", 25);
    start_conv(24'h989680, 1'b1);
    expect_result("10000000", 25);
    start_conv(24'hFFFFFF, 1'b1);
    expect_result("ffffff", 25);
    start_conv(24'd12345, 1'b1);
    expect_result("12345", 25);

    // Start held high across a conversion; data_bin changes mid-way.
    v0 = vcnt;
    sb_q.push_back(model(24'd1000));
    data_bin = 24'd1000;
    start    = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    data_bin = 24'd55;
    expect_result("hold 1000", 13);
    sb_q.push_back(model(24'd55));
    start = 1'b0;
    check("hold single_pulse", 64'(vcnt - v0), 64'(1));
    check("hold restart_busy", 64'(busy), 64'(1));
    expect_result("hold 55", 25);
    tick();
    tick();

    // Reset in the middle of a conversion aborts it.
    v0 = vcnt;
    start_conv(24'd999, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("abort held_data", 64'(data_bcd), 64'(28'h0000055));
    check("abort busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("abort data_bcd", 64'(data_bcd), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort valid", 64'(valid), 64'(0));
    check("abort ovf", 64'(ovf), 64'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("abort no_pulse", 64'(vcnt - v0), 64'(0));
    check("abort idle_busy", 64'(busy), 64'(0));
    check("abort idle_data", 64'(data_bcd), 64'(0));

    start_conv(24'd42, 1'b1);
    expect_result("after_abort 42", 25);
    check("scoreboard drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
